seven_seg_mux_n: RTL

- Parametrised multiplexed driver for an N-digit common-anode/cathode seven-segment display.
- Generalises the fixed 4-digit dice/point display.
- Adds the following:
  - per-digit hex data
  - per-digit enable, decimal point and blink
  - inter-digit ghost blanking
  - frame-coherent double-buffered update, so a value change never tears mid-frame.
- Sits between game/control logic and the board display pins.

---
 rtl/seven_seg_mux_n.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_mux_n.sv
// Purpose : multiplexed N-digit seven-segment driver with per-digit enable/dp/blink,
//           ghost blanking between digits and frame-coherent double-buffered updates.
// Latency : outputs registered, one cycle after prescaler/index state; loads show from the next frame.
// Backpressure: none; load is a pulse accepted on any cycle, last load before a frame boundary wins.
// Ports   : clk, rst (async active-low); digits/digit_en/dp/blink_mask + load in;
//           seg {g..a}, dp_out, an (one-hot), frame_start (1-cycle pulse) out.
module seven_seg_mux_n #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 200,
    parameter int BLINK_DIV      = 25000000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    // Timing state
    logic [PW-1:0] presc_q, presc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          bphase_q, bphase_d;

    // Pending (written by load) and active (shown) buffers
    logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_bk_q, pend_bk_d, act_bk_q, act_bk_d;

    // Output registers hold active-high values; polarity is applied at the pins
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fs_q, fs_d;

    logic       presc_wrap;
    logic       frame_edge;
    logic [3:0] nib;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        frame_edge = presc_wrap && (idx_q == IDX_MAX);

        presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end

        bcnt_d   = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + BW'(1);
        bphase_d = (bcnt_q == BLINK_MAX) ? ~bphase_q : bphase_q;

        pend_dig_d = load ? digits     : pend_dig_q;
        pend_en_d  = load ? digit_en   : pend_en_q;
        pend_dp_d  = load ? dp         : pend_dp_q;
        pend_bk_d  = load ? blink_mask : pend_bk_q;

        // Taking the pending *next* value lets a load on the boundary edge bypass
        // straight into the frame that is just starting.
        act_dig_d = frame_edge ? pend_dig_d : act_dig_q;
        act_en_d  = frame_edge ? pend_en_d  : act_en_q;
        act_dp_d  = frame_edge ? pend_dp_d  : act_dp_q;
        act_bk_d  = frame_edge ? pend_bk_d  : act_bk_q;

        fs_d = frame_edge;
    end

    always_comb begin
        nib  = act_dig_q[{idx_q, 2'b00} +: 4];
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        // Leading part of each slot keeps all anodes off so the previous digit's
        // segments cannot ghost onto the next anode while they settle.
        if (presc_q >= BLANK_END) begin
            an_d[idx_q] = 1'b1;
            if (act_en_q[idx_q] && !(act_bk_q[idx_q] && !bphase_q)) begin
                seg_d = hex_decode(nib);
                dp_d  = act_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            bphase_q   <= 1'b1;
            pend_dig_q <= '0;
            pend_en_q  <= '0;
            pend_dp_q  <= '0;
            pend_bk_q  <= '0;
            act_dig_q  <= '0;
            act_en_q   <= '0;
            act_dp_q   <= '0;
            act_bk_q   <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
            fs_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            bphase_q   <= bphase_d;
            pend_dig_q <= pend_dig_d;
            pend_en_q  <= pend_en_d;
            pend_dp_q  <= pend_dp_d;
            pend_bk_q  <= pend_bk_d;
            act_dig_q  <= act_dig_d;
            act_en_q   <= act_en_d;
            act_dp_q   <= act_dp_d;
            act_bk_q   <= act_bk_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fs_q       <= fs_d;
        end
    end

    assign seg         = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp_out      = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign an          = AN_ACTIVE_LOW  ? ~an_q  : an_q;
    assign frame_start = fs_q;

endmodule
